// File: rtl/branch_predict_ctrl.sv
// Pattern history table sequencing: gshare index, one-slot lookup/train tracking,
// mispredict/flush history repair and saturating stats. Define BP_GHR_EN for gshare.
module branch_predict_ctrl #(
  parameter int IWIDTH = 6,
  parameter int HWIDTH = 6,
  parameter int PC_LSB = 2,
  parameter int SWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush_req,
  input  logic              f_is_branch,
  input  logic [31:0]       f_pc,
  input  logic              f_backward,
  input  logic              d_resolved,
  input  logic              d_taken,
  input  logic              pht_pred,
  output logic              pht_en,
  output logic              pht_do_lookup,
  output logic              pht_do_update,
  output logic              pht_last_taken,
  output logic              pht_fallback,
  output logic [IWIDTH-1:0] pht_index,
  output logic              pred_taken,
  output logic              mispredict,
  output logic [HWIDTH-1:0] ghr,
  output logic [SWIDTH-1:0] n_branch,
  output logic [SWIDTH-1:0] n_miss
);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              pred_q, pred_d;
  logic [SWIDTH-1:0] n_branch_q, n_branch_d;
  logic [SWIDTH-1:0] n_miss_q, n_miss_d;
  logic              adv;
  logic [IWIDTH-1:0] pc_bits;
  logic              unused_pc;

  assign adv            = !reset && !stall && !flush_req;
  assign pc_bits        = f_pc[PC_LSB +: IWIDTH];
  assign unused_pc      = ^f_pc;
  assign pht_en         = !stall && !reset;
  assign pht_fallback   = f_backward;
  assign pht_do_lookup  = !reset && f_is_branch && (state_q == RUN) && !flush_req;
  assign pred_taken     = pht_do_lookup && pht_pred;
  assign pht_do_update  = !reset && d_resolved && valid_q && !flush_req;
  assign pht_last_taken = d_taken;
  assign mispredict     = pht_do_update && (d_taken != pred_q);
  assign n_branch       = n_branch_q;
  assign n_miss         = n_miss_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    pred_d     = pred_q;
    n_branch_d = n_branch_q;
    n_miss_d   = n_miss_q;
    if (flush_req) begin
      state_d = RUN;
      valid_d = 1'b0;
    end else if (adv) begin
      state_d = mispredict ? RECOVER : RUN;
      valid_d = pht_do_lookup;
      if (pht_do_lookup) pred_d = pred_taken;
      if (pht_do_update && (n_branch_q != {SWIDTH{1'b1}})) n_branch_d = n_branch_q + 1'b1;
      if (mispredict && (n_miss_q != {SWIDTH{1'b1}})) n_miss_d = n_miss_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      valid_q    <= 1'b0;
      pred_q     <= 1'b0;
      n_branch_q <= '0;
      n_miss_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pred_q     <= pred_d;
      n_branch_q <= n_branch_d;
      n_miss_q   <= n_miss_d;
    end
  end

`ifdef BP_GHR_EN
  logic [HWIDTH-1:0] ghr_q, ghr_d;
  logic [HWIDTH-1:0] ckpt_q, ckpt_d;

  assign ghr       = ghr_q;
  assign pht_index = pc_bits ^ IWIDTH'(ghr_q);

  // Repair restarts from the history seen by the mispredicted branch, not the current one.
  always_comb begin
    ghr_d  = ghr_q;
    ckpt_d = ckpt_q;
    if (flush_req) begin
      if (valid_q) ghr_d = ckpt_q;
    end else if (adv) begin
      if (mispredict) ghr_d = HWIDTH'({ckpt_q, d_taken});
      else if (pht_do_lookup) ghr_d = HWIDTH'({ghr_q, pred_taken});
      if (pht_do_lookup) ckpt_d = ghr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q  <= '0;
      ckpt_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      ckpt_q <= ckpt_d;
    end
  end
`else
  assign ghr       = '0;
  assign pht_index = pc_bits;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_branch_predict_ctrl;
  localparam int SW = 4;
  localparam logic [SW-1:0] SMAX = {SW{1'b1}};
`ifdef BP_GHR_EN
  localparam bit GHR_ON = 1'b1;
`else
  localparam bit GHR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, stall = 1'b0, flush_req = 1'b0, f_is_branch = 1'b0;
  logic [31:0] f_pc = 32'h0;
  logic f_backward = 1'b0, d_resolved = 1'b0, d_taken = 1'b0, pht_pred = 1'b0;
  logic pht_en, pht_do_lookup, pht_do_update, pht_last_taken, pht_fallback;
  logic [5:0] pht_index, ghr;
  logic pred_taken, mispredict;
  logic [SW-1:0] n_branch, n_miss;

  int n_vec = 0;
  int n_err = 0;

  branch_predict_ctrl #(.IWIDTH(6), .HWIDTH(6), .PC_LSB(2), .SWIDTH(SW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_req(flush_req),
    .f_is_branch(f_is_branch), .f_pc(f_pc), .f_backward(f_backward),
    .d_resolved(d_resolved), .d_taken(d_taken), .pht_pred(pht_pred),
    .pht_en(pht_en), .pht_do_lookup(pht_do_lookup), .pht_do_update(pht_do_update),
    .pht_last_taken(pht_last_taken), .pht_fallback(pht_fallback), .pht_index(pht_index),
    .pred_taken(pred_taken), .mispredict(mispredict), .ghr(ghr),
    .n_branch(n_branch), .n_miss(n_miss)
  );

  always #5 clk = ~clk;

  // Reference model: the front end tracks one in-flight branch and its history snapshot.
  logic [5:0] m_ghr = '0, m_ckpt = '0;
  logic m_valid = 1'b0, m_pred = 1'b0, m_rec = 1'b0;
  logic [SW-1:0] m_nbr = '0, m_nmiss = '0;
  logic e_en, e_look, e_pred, e_upd, e_mis;
  logic [5:0] e_idx, e_ghr_next;

  always_comb begin
    e_en   = !stall && !reset;
    e_look = !reset && f_is_branch && !m_rec && !flush_req;
    e_pred = e_look && pht_pred;
    e_upd  = !reset && d_resolved && m_valid && !flush_req;
    e_mis  = e_upd && (d_taken != m_pred);
    e_idx  = f_pc[7:2] ^ m_ghr;
    e_ghr_next = m_ghr;
    if (e_mis) e_ghr_next = {m_ckpt[4:0], d_taken};
    else if (e_look) e_ghr_next = {m_ghr[4:0], e_pred};
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ghr <= '0; m_ckpt <= '0; m_valid <= 1'b0; m_pred <= 1'b0;
      m_rec <= 1'b0; m_nbr <= '0; m_nmiss <= '0;
    end else if (flush_req) begin
      if (m_valid && GHR_ON) m_ghr <= m_ckpt;
      m_valid <= 1'b0;
      m_rec   <= 1'b0;
    end else if (!stall) begin
      if (GHR_ON) m_ghr <= e_ghr_next;
      if (e_look) begin
        m_ckpt <= m_ghr;
        m_pred <= e_pred;
      end
      m_valid <= e_look;
      m_rec   <= e_mis;
      if (e_upd && m_nbr != SMAX) m_nbr <= m_nbr + 1'b1;
      if (e_mis && m_nmiss != SMAX) m_nmiss <= m_nmiss + 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("pht_en", 32'(pht_en), 32'(e_en));
    chk("pht_do_lookup", 32'(pht_do_lookup), 32'(e_look));
    chk("pht_do_update", 32'(pht_do_update), 32'(e_upd));
    chk("pht_last_taken", 32'(pht_last_taken), 32'(d_taken));
    chk("pht_fallback", 32'(pht_fallback), 32'(f_backward));
    chk("pht_index", 32'(pht_index), 32'(e_idx));
    chk("pred_taken", 32'(pred_taken), 32'(e_pred));
    chk("mispredict", 32'(mispredict), 32'(e_mis));
    chk("ghr", 32'(ghr), 32'(m_ghr));
    chk("n_branch", 32'(n_branch), 32'(m_nbr));
    chk("n_miss", 32'(n_miss), 32'(m_nmiss));
  end

  // Applies one cycle of inputs just after a rising edge; returns mid-cycle for literal checks.
  task automatic cyc(input logic rst, input logic st, input logic fl, input logic br,
                     input logic [31:0] pc, input logic bk, input logic rs,
                     input logic tk, input logic pr);
    @(posedge clk);
    #1;
    reset = rst; stall = st; flush_req = fl; f_is_branch = br; f_pc = pc;
    f_backward = bk; d_resolved = rs; d_taken = tk; pht_pred = pr;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 1, 32'h40, 0, 1, 1, 1);
    chk("rst_pht_en", 32'(pht_en), 32'd0);
    chk("rst_lookup", 32'(pht_do_lookup), 32'd0);
    chk("rst_ghr", 32'(ghr), 32'd0);
    cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, 0);

    // First lookup at 0x40 from empty history, then correct taken resolve.
    cyc(0, 0, 0, 1, 32'h40, 1, 0, 0, 1);
    chk("A_index", 32'(pht_index), 32'h10);
    chk("A_lookup", 32'(pht_do_lookup), 32'd1);
    chk("A_fallback", 32'(pht_fallback), 32'd1);
    chk("A_pred", 32'(pred_taken), 32'd1);
    cyc(0, 0, 0, 0, 32'h40, 0, 1, 1, 0);
    chk("A_update", 32'(pht_do_update), 32'd1);
    chk("A_misp", 32'(mispredict), 32'd0);
    chk("A_ghr", 32'(ghr), GHR_ON ? 32'h01 : 32'h0);
    idle();
    chk("A_nbranch", 32'(n_branch), 32'd1);

    // Build ghr = 0x05, then mispredict not-taken vs taken.
    cyc(0, 0, 0, 1, 32'h44, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h48, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 32'h0, 0, 1, 1, 0);
    chk("B_ghr5", 32'(ghr), GHR_ON ? 32'h05 : 32'h0);
    cyc(0, 0, 0, 1, 32'h4C, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0, 1, 1, 0);
    chk("B_misp", 32'(mispredict), 32'd1);
    cyc(0, 0, 0, 1, 32'h50, 0, 0, 0, 1);
    chk("B_recover_lookup", 32'(pht_do_lookup), 32'd0);
    chk("B_ghr_repair", 32'(ghr), GHR_ON ? 32'h0B : 32'h0);
    chk("B_nmiss", 32'(n_miss), 32'd1);
    chk("B_index", 32'(pht_index), GHR_ON ? 32'h14 ^ 32'h0B : 32'h14);

    // Lookup, three stall cycles, then resolve.
    cyc(0, 0, 0, 1, 32'h50, 0, 0, 0, 1);
    chk("C_lookup", 32'(pht_do_lookup), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 32'h0, 0, 0, 0, 0);
      chk("C_stall_en", 32'(pht_en), 32'd0);
      chk("C_stall_ghr", 32'(ghr), GHR_ON ? 32'h17 : 32'h0);
    end
    cyc(0, 0, 0, 0, 32'h0, 0, 1, 1, 0);
    chk("C_update", 32'(pht_do_update), 32'd1);
    chk("C_misp", 32'(mispredict), 32'd0);

    // Reset with a branch in flight discards it.
    cyc(0, 0, 0, 1, 32'h54, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 32'h0, 0, 1, 0, 0);
    chk("D_rst_update", 32'(pht_do_update), 32'd0);
    chk("D_rst_misp", 32'(mispredict), 32'd0);
    cyc(0, 0, 0, 0, 32'h0, 0, 1, 1, 0);
    chk("D_no_train", 32'(pht_do_update), 32'd0);
    chk("D_nbranch0", 32'(n_branch), 32'd0);

    // Reach ghr = 0x02, look up with pred 1, then flush together with resolve.
    cyc(0, 0, 0, 1, 32'h60, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h64, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 32'h68, 0, 1, 0, 1);
    chk("D_ckpt_src", 32'(ghr), GHR_ON ? 32'h02 : 32'h0);
    cyc(0, 0, 1, 1, 32'h6C, 0, 1, 0, 0);
    chk("D_flush_update", 32'(pht_do_update), 32'd0);
    chk("D_flush_lookup", 32'(pht_do_lookup), 32'd0);
    idle();
    chk("D_flush_ghr", 32'(ghr), GHR_ON ? 32'h02 : 32'h0);
    chk("D_flush_nbranch", 32'(n_branch), 32'd2);

    // Saturate both counters with repeated mispredicts.
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 0, 1, 32'h70, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 32'h0, 0, 1, 1, 0);
      idle();
    end
    chk("E_nmiss_sat", 32'(n_miss), 32'(SMAX));
    chk("E_nbranch_sat", 32'(n_branch), 32'(SMAX));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Sequencing controller for the pattern history table in the FETCH/DECODE front end. Forms the table index from the fetch PC and a speculative global history register (gshare), and drives table enable, lookup and update so that every lookup made in FETCH is trained exactly once when the branch resolves in DECODE. Also detects mispredictions, repairs the history after a mispredict or flush, and keeps saturating statistics counters.

## Interface
- IWIDTH, 6: table index width; must match the table's IWIDTH.
- HWIDTH, 6: global history length; 1 ≤ HWIDTH ≤ IWIDTH.
- PC_LSB, 2: lowest PC bit used for indexing.
- SWIDTH, 16: statistics counter width.

Ports:
- clk  in  1  clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  front-end stall: FETCH and DECODE hold.
- flush_req  in  1  later-stage flush; kills the FETCH and DECODE instructions.
- f_is_branch  in  1  the instruction in FETCH is a conditional branch.
- f_pc  in  32  PC of the instruction in FETCH.
- f_backward  in  1  the branch in FETCH has a negative offset (static hint).
- d_resolved  in  1  a branch in DECODE resolved this cycle.
- d_taken  in  1  resolved direction.
- pht_pred  in  1  prediction returned by the table.
- pht_en  out  1  table enable.
- pht_do_lookup  out  1  table lookup strobe.
- pht_do_update  out  1  table update strobe.
- pht_last_taken  out  1  training direction sent to the table.
- pht_fallback  out  1  static default prediction sent to the table.
- pht_index  out  IWIDTH  table index.
- pred_taken  out  1  prediction for the instruction in FETCH.
- mispredict  out  1  redirect request.
- ghr  out  HWIDTH  speculative global history.
- n_branch  out  SWIDTH  count of trained branches.
- n_miss  out  SWIDTH  count of mispredictions.

## Operation
- Enabled cycle (adv): reset low, stall low, flush_req low.
- pht_en = !stall && !reset.
- pht_fallback = f_backward (backward-taken / forward-not-taken).
- pht_index = f_pc[PC_LSB +: IWIDTH] XOR zero-extended ghr.
- FSM states: RUN and RECOVER.
  - RUN → RECOVER on an adv cycle with mispredict = 1.
  - RECOVER → RUN on the next adv cycle.
  - flush_req forces RUN.
- Lookup:
  - pht_do_lookup = f_is_branch && state == RUN && !flush_req.
  - pred_taken = pht_do_lookup ? pht_pred : 0.
  - In RECOVER the FETCH slot holds the wrong-path instruction, so no lookup is made and no slot is allocated.
- In-flight slot (valid, pred, checkpoint):
  - Loaded on an adv cycle with pht_do_lookup: valid = 1, pred = pred_taken, checkpoint = pre-shift ghr.
  - Cleared on any other adv cycle.
  - The same adv cycle shifts ghr ← {ghr[HWIDTH-2:0], pred_taken}.
- Resolve: the slot matches DECODE when d_resolved && valid.
  - pht_do_update = d_resolved && valid && !flush_req.
  - pht_last_taken = d_taken.
  - mispredict = pht_do_update && (d_taken != pred).
  - d_resolved with valid = 0 is ignored: no update, no count.
- GHR repair on an adv cycle with mispredict: ghr ← {checkpoint[HWIDTH-2:0], d_taken}.
  - This overrides any shift from the same cycle; no lookup can coincide with it anyway, because FETCH is wrong-path.
- Flush: ghr ← checkpoint if valid, else unchanged. The slot is cleared and no update is made.
  - flush_req has priority over resolve and lookup in the same cycle.
- Statistics: each update increments n_branch, and each mispredict increments n_miss, on adv cycles only. Both saturate at all-ones.

## Timing
- Reset values: ghr = 0, slot valid = 0, state = RUN, n_branch = 0, n_miss = 0.
  - While reset is high: pht_en, pht_do_lookup, pht_do_update, pred_taken and mispredict are all 0.
  - Reset mid-operation discards the in-flight slot with no training.
- Lookup to update: exactly 1 adv cycle. Stall cycles in between hold all state; the table's last_index is preserved because pht_en = 0.
- pred_taken and mispredict are combinational, valid in the same cycle as the lookup and the resolve respectively.
- RECOVER lasts exactly 1 adv cycle; stalls extend it.

## Configuration
- BP_GHR_EN defined: gshare indexing and GHR as described.
- BP_GHR_EN undefined (bimodal):
  - pht_index = f_pc[PC_LSB +: IWIDTH].
  - ghr output tied to 0; no history registers, no checkpoint.
  - Flush and mispredict perform no history repair.
  - FSM, slot and statistics unchanged.

## Test plan
- Reset, then a branch at f_pc = 0x40 with ghr = 0 (IWIDTH = 6) → pht_index = 0x10; pht_do_lookup = 1; pht_fallback follows f_backward.
- Lookup with pht_pred = 1, next adv cycle d_resolved = 1, d_taken = 1 → pht_do_update = 1, mispredict = 0; ghr = 0x01; n_branch = 1.
- Starting from ghr = 0x05, lookup with pht_pred = 0, resolve with d_taken = 1 → mispredict = 1, ghr = 0x0B.
  - The following cycle is RECOVER: pht_do_lookup = 0 despite f_is_branch = 1. n_miss = 1.
- Lookup, then stall for 3 cycles, then resolve → the single update occurs only after stall drops; pht_en = 0 during the stall; ghr is unchanged during the stall.
- Lookup with pred 1 from ghr = 0x02, then flush_req together with d_resolved → no update, ghr = 0x02, no count change.
- Force n_miss to all-ones, then mispredict → n_miss stays all-ones.
- Without BP_GHR_EN → ghr stays 0 and pht_index equals the PC bits in all of the scenarios above.
